button_debouncer: RTL and testbench

Synchronises and debounces the raw board push-button lines and presents clean, active-high level outputs. These outputs drive the 4-bit `in_port` of the Avalon button PIO. The block also produces one-cycle press/release event pulses for local logic. It sits between the FPGA button pins and the button PIO, in the PIO's clock domain.

---
 rtl/button_pkg.sv | 14 +
 rtl/button_debounce_cell.sv | 68 ++++++
 rtl/button_debouncer.sv | 35 +++
 tb/tb_button_debouncer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and types for the push-button front end feeding the button PIO.
package button_pkg;

  localparam int BTN_WIDTH_DEFAULT      = 4;
  localparam int BTN_DEBOUNCE_1MS_50MHZ = 50000;

  typedef logic [3:0] btn_vec_t;

  // Pin level of a released button: high for pull-up wiring, low otherwise.
  function automatic logic idle_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/button_debounce_cell.sv
// One button line: synchroniser chain, stability counter, debounced state flop
// and registered press/release pulses.
module button_debounce_cell
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_1MS_50MHZ,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int                     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{idle_level(ACTIVE_LOW)}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   pressed;

  always_comb begin
    pressed   = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any sample agreeing with the accepted state restarts the stability run.
    if (pressed == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d   = pressed;
      cnt_d     = '0;
      press_d   = pressed;
      release_d = ~pressed;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= SYNC_RST;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], button_i};
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH raw button pins into clean active-high levels for the PIO
// in_port, plus one-cycle press/release pulses for local logic.
module button_debouncer
  import button_pkg::*;
#(
  parameter int WIDTH           = BTN_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_1MS_50MHZ,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] button_in,
  output logic [WIDTH-1:0] button_state,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  // Lines are fully independent, so each gets its own cell.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
    button_debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .button_i (button_in[gi]),
      .state_o  (button_state[gi]),
      .press_o  (press_pulse[gi]),
      .release_o(release_pulse[gi])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and randomised checks of button_debouncer against a sliding-window
// model: a bit flips once its last DEBOUNCE samples (delayed by SYNC) all disagree.
module tb_button_debouncer;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int HN = S + D;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] button_in = 4'hF;
  logic [W-1:0] button_state, press_pulse, release_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: hist[0] is the pressed-level sampled at the latest edge.
  logic [W-1:0] hist [0:HN-1];
  logic [W-1:0] exp_state, exp_press, exp_release;
  int           pcnt [0:W-1];
  int           rcnt [0:W-1];

  button_debouncer #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_in    (button_in),
    .button_state (button_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < HN; j++) hist[j] = '0;
    exp_state   = '0;
    exp_press   = '0;
    exp_release = '0;
  endtask

  task automatic clear_counts();
    for (int b = 0; b < W; b++) begin
      pcnt[b] = 0;
      rcnt[b] = 0;
    end
  endtask

  task automatic model_edge();
    logic all_diff;
    for (int j = HN - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0]     = ~button_in;
    exp_press   = '0;
    exp_release = '0;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = S; j < HN; j++)
        if (hist[j][b] == exp_state[b]) all_diff = 1'b0;
      if (all_diff) begin
        exp_state[b] = ~exp_state[b];
        if (exp_state[b]) exp_press[b] = 1'b1;
        else              exp_release[b] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("state", button_state, exp_state);
    chk("press", press_pulse, exp_press);
    chk("release", release_pulse, exp_release);
    chk("excl", press_pulse & release_pulse, 4'h0);
    for (int b = 0; b < W; b++) begin
      if (press_pulse[b])   pcnt[b]++;
      if (release_pulse[b]) rcnt[b]++;
    end
  endtask

  // Called at a negedge: drive, let one rising edge sample, check at next negedge.
  task automatic step(input logic [W-1:0] raw);
    button_in = raw;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw);
  endtask

  initial begin
    int bounce [0:3];
    logic [W-1:0] raw;
    bounce[0] = 1; bounce[1] = 2; bounce[2] = 1; bounce[3] = 3;
    model_reset();
    clear_counts();

    // Reset held with all buttons released
    button_in = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    reset_n = 1'b1;
    hold(4'hF, 4);

    // Clean press on bit0: accepted on edge 6, pulse gone on edge 7
    for (int e = 1; e <= 8; e++) begin
      step(4'hE);
      if (e == 5) chk("clean_pre_state", button_state, 4'h0);
      if (e == 6) chk("clean_press_e6", press_pulse, 4'h1);
      if (e == 6) chk("clean_state_e6", button_state, 4'h1);
      if (e == 7) chk("clean_press_e7", press_pulse, 4'h0);
    end
    hold(4'hF, 8);
    chk("clean_release_state", button_state, 4'h0);

    // Glitch of 3 cycles on bit1 rejected, then a long press accepted
    clear_counts();
    hold(4'hD, 3);
    hold(4'hF, 8);
    chk("glitch_state", button_state, 4'h0);
    n_tests++;
    assert (pcnt[1] == 0) else begin
      n_fail++;
      $error("FAIL glitch_pulses observed=%0d expected=0", pcnt[1]);
    end
    for (int e = 1; e <= 8; e++) begin
      step(4'hD);
      if (e == 6) chk("glitch_accept_e6", press_pulse, 4'h2);
    end
    hold(4'hF, 8);

    // Bounce train on bit2, press then release
    clear_counts();
    for (int p = 0; p < 4; p++) hold((p % 2 == 0) ? 4'hB : 4'hF, bounce[p]);
    for (int e = 1; e <= 8; e++) begin
      step(4'hB);
      if (e == 6) chk("bounce_press_e6", press_pulse, 4'h4);
    end
    for (int p = 0; p < 4; p++) hold((p % 2 == 0) ? 4'hF : 4'hB, bounce[p]);
    for (int e = 1; e <= 8; e++) begin
      step(4'hF);
      if (e == 6) chk("bounce_release_e6", release_pulse, 4'h4);
    end
    n_tests++;
    assert (pcnt[2] == 1 && rcnt[2] == 1) else begin
      n_fail++;
      $error("FAIL bounce_counts observed=%0d/%0d expected=1/1", pcnt[2], rcnt[2]);
    end

    // Bits 0 and 3 together, with a short glitch on bit1
    for (int e = 1; e <= 8; e++) begin
      step((e == 3 || e == 4) ? 4'h4 : 4'h6);
      if (e == 6) chk("simul_press_e6", press_pulse, 4'h9);
      if (e == 6) chk("simul_state_e6", button_state, 4'h9);
    end
    hold(4'hF, 8);

    // Reset mid-count: counter has reached 2 when reset hits
    hold(4'hE, 4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_async_state", button_state, 4'h0);
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(4'hE);
      if (e == 5) chk("midreset_e5", press_pulse, 4'h0);
      if (e == 6) chk("midreset_e6", press_pulse, 4'h1);
    end
    hold(4'hF, 8);

    // Random walk: each bit toggles occasionally so both short and long runs occur
    raw = 4'hF;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 4) == 0) raw[b] = ~raw[b];
      step(raw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
